// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multi-cycle MULTU/DIVU controller: ALU control codes,
// FSM state encoding and operation selects.
package alu_muldiv_seq_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer: borrows the shared ALU for one add or subtract
// per cycle (shift-add multiply, restoring divide) and accumulates the result in HI/LO.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dz_q, dz_d;

  logic             r_msb;
  logic [WIDTH-1:0] rs;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      count_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      count_q <= count_d;
      dz_q    <= dz_d;
    end
  end

  // Remainder shifted left by one, with the bit that falls off kept separately
  assign r_msb = hi_q[WIDTH-1];
  assign rs    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  // Next-state, datapath update and ALU drive
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    count_d  = count_q;
    dz_d     = dz_q;
    alu_ctrl = ALU_AND;
    alu_a    = '0;
    alu_b    = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dz_d    = 1'b0;
          hi_d    = '0;
          lo_d    = src_a;
          opnd_d  = src_b;
          count_d = '0;
          if (op == OP_MULTU) begin
            state_d = S_MUL;
          end else if (src_b != '0) begin
            state_d = S_DIV;
          end else begin
            // Divide by zero finishes immediately with MIPS-style fill values
            state_d = S_DONE;
            hi_d    = src_a;
            lo_d    = '1;
            dz_d    = 1'b1;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_MUL: begin
        alu_ctrl     = ALU_ADD;
        alu_a        = hi_q;
        alu_b        = lo_q[0] ? opnd_q : '0;
        {hi_d, lo_d} = {alu_cf, alu_out, lo_q[WIDTH-1:1]};
      end

      S_DIV: begin
        alu_ctrl = ALU_SUB;
        alu_a    = rs;
        alu_b    = opnd_q;
        if (r_msb || !alu_cf) begin
          hi_d = alu_out;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rs;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Shared iteration counter for both multi-cycle operations
    if (state_q == S_MUL || state_q == S_DIV) begin
      if (count_q == CW'(WIDTH - 1)) begin
        state_d = S_DONE;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign done     = (state_q == S_DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural model of the shared ALU.
module tb_alu_muldiv_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic         alu_cf;
  logic [W:0]   sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cf(alu_cf)
  );

  // Shared execute-stage ALU
  always_comb begin
    sum     = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out = '0;
    alu_cf  = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: {alu_cf, alu_out} = sum;
      4'b0110: begin
        alu_out = alu_a - alu_b;
        alu_cf  = (alu_a < alu_b);
      end
      4'b0111: alu_out = {{(W-1){1'b0}}, (alu_a < alu_b)};
      4'b1100: alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
  end

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges from acceptance until done, and cycles sampled with busy high
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    total++; if (hi !== '0 || lo !== '0) begin bad++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo); end
    total++; if (alu_ctrl !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", alu_ctrl); end
  endtask

  task automatic test_multu_small();
    int lat, bcnt;
    issue(1'b0, 32'd7, 32'd6);
    total++; if (alu_ctrl !== 4'b0010) begin bad++; $display("FAIL mul_ctrl got=%b exp=0010", alu_ctrl); end
    wait_done(lat, bcnt);
    total++; if (lat !== 32) begin bad++; $display("FAIL mul_latency got=%0d exp=32", lat); end
    total++; if (bcnt !== 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=32", bcnt); end
    total++; if (hi !== 32'd0 || lo !== 32'd42) begin bad++; $display("FAIL mul_7x6 got=%h_%h exp=0_2a", hi, lo); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL mul_dz got=%b exp=0", div_zero); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin
      bad++; $display("FAIL mul_hold got done=%b %h_%h exp done=0 0_2a", done, hi, lo); end
  endtask

  task automatic test_multu_max();
    int lat, bcnt;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    total++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      bad++; $display("FAIL mul_max got=%h_%h exp=fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_divu();
    int lat, bcnt;
    issue(1'b1, 32'd100, 32'd7);
    total++; if (alu_ctrl !== 4'b0110) begin bad++; $display("FAIL div_ctrl got=%b exp=0110", alu_ctrl); end
    wait_done(lat, bcnt);
    total++; if (lat !== 32) begin bad++; $display("FAIL div_latency got=%0d exp=32", lat); end
    total++; if (lo !== 32'd14 || hi !== 32'd2) begin bad++; $display("FAIL div_100_7 got q=%0d r=%0d exp q=14 r=2", lo, hi); end
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    wait_done(lat, bcnt);
    total++; if (lo !== 32'd1 || hi !== 32'h7FFF_FFFE) begin
      bad++; $display("FAIL div_rmsb got q=%h r=%h exp q=00000001 r=7ffffffe", lo, hi); end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    issue(1'b1, 32'd1234, 32'd0);
    wait_done(lat, bcnt);
    total++; if (lat !== 0) begin bad++; $display("FAIL dz_latency got=%0d exp=0", lat); end
    total++; if (hi !== 32'd1234 || lo !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL dz_values got=%h_%h exp=000004d2_ffffffff", hi, lo); end
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
    total++; if (alu_ctrl !== 4'b0000 || bcnt !== 0) begin
      bad++; $display("FAIL dz_alu_idle got ctrl=%b busy_cycles=%0d exp 0000/0", alu_ctrl, bcnt); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    issue(1'b0, 32'd3, 32'd5);
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL b2b_dz_clear got=%b exp=0", div_zero); end
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5 || lat == 20) begin
        start = 1'b1; op = 1'b1; src_a = 32'd99; src_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++; if (lat !== 32) begin bad++; $display("FAIL ignore_latency got=%0d exp=32", lat); end
    total++; if (hi !== 32'd0 || lo !== 32'd15 || div_zero !== 1'b0) begin
      bad++; $display("FAIL ignore_result got=%h_%h dz=%b exp=0_f dz=0", hi, lo, div_zero); end
    issue(1'b1, 32'd9, 32'd2);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept got done=%b busy=%b exp 0/1", done, busy); end
    wait_done(lat, bcnt);
    total++; if (lo !== 32'd4 || hi !== 32'd1) begin bad++; $display("FAIL b2b_div got q=%0d r=%0d exp q=4 r=1", lo, hi); end
  endtask

  task automatic test_abort();
    int lat, bcnt;
    bit seen;
    issue(1'b1, 32'd100, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_pre got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      bad++; $display("FAIL abort_clear got busy=%b %h_%h exp 0 0_0", busy, hi, lo); end
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    issue(1'b0, 32'd2, 32'd3);
    wait_done(lat, bcnt);
    total++; if (hi !== 32'd0 || lo !== 32'd6) begin bad++; $display("FAIL abort_after got=%h_%h exp=0_6", hi, lo); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_multu_small();
    test_multu_max();
    test_divu();
    test_div_zero();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
